// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   state_t    : sequencer FSM states
//   npc_sel_t  : next-PC source select codes driven into npc_calc
//   PC_W       : program counter width
package pc_seq_pkg;

  localparam int PC_W = 8;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NPC_HOLD = 2'd0,
    NPC_INC  = 2'd1,
    NPC_BR   = 2'd2,
    NPC_JMP  = 2'd3
  } npc_sel_t;

endpackage

// File: rtl/pc_sequencer_npc_calc.sv
// npc_calc: combinational next-PC arithmetic for the sequencer.
// Ports:
//   pc         in  8  current program counter
//   jump_in    in  8  jump field; low (8-PAGE_BITS) bits replace the PC in-page offset
//   branch_off in  8  two's complement branch offset, applied to pc+1
//   sel        in  2  next-PC source (hold / increment / branch / page jump)
//   next_pc    out 8  selected next program counter
module npc_calc
  import pc_seq_pkg::*;
#(
  parameter int PAGE_BITS = 3
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] jump_in,
  input  logic [PC_W-1:0] branch_off,
  input  npc_sel_t        sel,
  output logic [PC_W-1:0] next_pc
);

  // Upper PAGE_BITS bits set: these bits are kept from the current PC on a jump.
  localparam logic [PC_W-1:0] HI_MASK = ~(8'hFF >> PAGE_BITS);

  logic [PC_W-1:0] page_target;
  logic [PC_W-1:0] branch_target;

  assign page_target   = (pc & HI_MASK) | (jump_in & ~HI_MASK);
  // 8-bit wrap makes the offset behave as signed without explicit extension.
  assign branch_target = pc + 8'd1 + branch_off;

  // Next-PC source mux.
  always_comb begin
    next_pc = pc;
    case (sel)
      NPC_HOLD: next_pc = pc;
      NPC_INC:  next_pc = pc + 8'd1;
      NPC_BR:   next_pc = branch_target;
      NPC_JMP:  next_pc = page_target;
      default:  next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the 8-bit fetch PC and sequences increment, taken
// branches and page-relative jumps, with stall, one-cycle redirect flush and
// halt/resume. All outputs are registered.
// Optional feature macro: JAL_LINK_EN (adds link_out/link_we return-address path).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall                     hazard hold, PC frozen
//   jump_req, jump_in         page jump request and jump field
//   branch_req, branch_taken  branch present / condition result
//   branch_off                signed branch offset
//   halt_req, resume          enter / leave HALT
//   pc_out, fetch_valid       fetch address and its valid flag
//   flush                     one-cycle kill of the already-fetched instruction
//   halted                    high while in HALT
//   link_out, link_we         return address and write strobe (JAL_LINK_EN)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         PAGE_BITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       jump_req,
  input  logic [7:0] jump_in,
  input  logic       branch_req,
  input  logic       branch_taken,
  input  logic [7:0] branch_off,
  input  logic       halt_req,
  input  logic       resume,
  output logic [7:0] pc_out,
  output logic       fetch_valid,
  output logic       flush,
`ifdef JAL_LINK_EN
  output logic [7:0] link_out,
  output logic       link_we,
`endif
  output logic       halted
);

  state_t          state;
  npc_sel_t        sel;
  logic [PC_W-1:0] next_pc;
  logic            br_taken;

  assign br_taken = branch_req & branch_taken;

  // Next-PC source: RUN follows the halt > stall > jump > branch > inc priority;
  // REDIRECT ignores decode inputs and just keeps fetching sequentially.
  always_comb begin
    sel = NPC_HOLD;
    case (state)
      RUN: begin
        if (halt_req)      sel = NPC_HOLD;
        else if (stall)    sel = NPC_HOLD;
        else if (jump_req) sel = NPC_JMP;
        else if (br_taken) sel = NPC_BR;
        else               sel = NPC_INC;
      end
      REDIRECT: sel = NPC_INC;
      default:  sel = NPC_HOLD;
    endcase
  end

  npc_calc #(
    .PAGE_BITS (PAGE_BITS)
  ) u_npc_calc (
    .pc         (pc_out),
    .jump_in    (jump_in),
    .branch_off (branch_off),
    .sel        (sel),
    .next_pc    (next_pc)
  );

  // Sequencer FSM with registered PC and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc_out      <= RESET_PC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      halted      <= 1'b0;
`ifdef JAL_LINK_EN
      link_out    <= 8'h00;
      link_we     <= 1'b0;
`endif
    end else begin
      pc_out <= next_pc;
      flush  <= 1'b0;
`ifdef JAL_LINK_EN
      link_we <= 1'b0;
`endif
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (halt_req) begin
            state       <= HALT;
            halted      <= 1'b1;
            fetch_valid <= 1'b0;
          end else if (stall) begin
            fetch_valid <= 1'b0;
          end else if (jump_req) begin
            state       <= REDIRECT;
            flush       <= 1'b1;
            fetch_valid <= 1'b1;
`ifdef JAL_LINK_EN
            link_out    <= pc_out + 8'd1;
            link_we     <= 1'b1;
`endif
          end else if (br_taken) begin
            state       <= REDIRECT;
            flush       <= 1'b1;
            fetch_valid <= 1'b1;
          end else begin
            fetch_valid <= 1'b1;
          end
        end
        REDIRECT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        HALT: begin
          // A simultaneous halt_req keeps the sequencer parked.
          if (resume && !halt_req) begin
            state       <= RUN;
            halted      <= 1'b0;
            fetch_valid <= 1'b1;
          end else begin
            fetch_valid <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
